// File: rtl/div_unit_pkg.sv
// div_unit_pkg
//   Shared configuration for the integer divider: datapath width, iteration
//   counts for full-width and word operations, counter width, and the state
//   encoding of the divider control FSM.
package div_unit_pkg;

  localparam int DIV_XLEN    = 64;
  localparam int DIV_ITER_64 = 64;
  localparam int DIV_ITER_32 = 32;

  // Must hold DIV_ITER_64 itself, not just DIV_ITER_64-1.
  localparam int DIV_CNT_W   = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage : div_unit_pkg

// File: rtl/div_step.sv
// div_step
//   One combinational iteration of the restoring shift-subtract divider.
//   Ports:
//     rem_i  - current partial remainder (always < divisor magnitude)
//     dvsr_i - divisor magnitude
//     bit_i  - next dividend bit, shifted in at the LSB
//     rem_o  - partial remainder after this iteration
//     q_o    - quotient bit produced by this iteration
module div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] dvsr_i,
  input  logic            bit_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  // The shifted remainder can need XLEN+1 bits; the trial difference carries
  // two sign bits on top of XLEN magnitude bits so it never wraps.
  assign shifted = {rem_i, bit_i};
  assign diff    = {1'b0, shifted} - {2'b00, dvsr_i};

  // Difference is non-negative (and below the divisor) only when both sign
  // bits are clear; any borrow sets both of them.
  assign q_o   = ~(diff[XLEN+1] | diff[XLEN]);

  // On borrow, restore: keep the shifted value. In that case shifted is
  // smaller than the divisor, so its top bit is zero and dropping it is safe.
  assign rem_o = q_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule : div_step

// File: rtl/div_unit.sv
// div_unit
//   Multi-cycle RV64M divider (DIV/DIVU/REM/REMU and *W variants). Restoring
//   algorithm, one quotient bit per cycle; divide-by-zero and signed overflow
//   are resolved at accept time without iterating.
//   Ports:
//     clk, rst_n            - clock, asynchronous active-low reset
//     div_valid_i/ready_o   - request handshake (ready only when idle)
//     div_signed_i          - 1: DIV/REM, 0: DIVU/REMU
//     div_word_i            - 1: *W op on bits [31:0], results sign-extended
//     dividend_i, divisor_i - operands (rs1, rs2)
//     flush_i               - abandons any operation; highest priority
//     out_valid_o/ready_i   - result handshake
//     quotient_o            - quotient, held while out_valid_o is high
//     remainder_o           - remainder, held while out_valid_o is high
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_valid_i,
  output logic            div_ready_o,
  input  logic            div_signed_i,
  input  logic            div_word_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]      rem_q, rem_d;
  // Holds the dividend magnitude (MSB first) and collects quotient bits from
  // the LSB as the dividend bits are consumed.
  logic [XLEN-1:0]      quo_q, quo_d;
  logic [XLEN-1:0]      dvsr_q, dvsr_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 word_q, word_d;
  logic [XLEN-1:0]      quotient_q, quotient_d;
  logic [XLEN-1:0]      remainder_q, remainder_d;

  // Operand preprocessing at accept time.
  logic [XLEN-1:0] op_a, op_b, mag_a, mag_b, min_val;
  logic            sign_a, sign_b, div_zero, sgn_ovf;

  always_comb begin
    if (div_word_i) begin
      op_a = div_signed_i ? sext_w(dividend_i[31:0]) : {{(XLEN-32){1'b0}}, dividend_i[31:0]};
      op_b = div_signed_i ? sext_w(divisor_i[31:0])  : {{(XLEN-32){1'b0}}, divisor_i[31:0]};
    end else begin
      op_a = dividend_i;
      op_b = divisor_i;
    end
    sign_a   = div_signed_i & op_a[XLEN-1];
    sign_b   = div_signed_i & op_b[XLEN-1];
    mag_a    = sign_a ? -op_a : op_a;
    mag_b    = sign_b ? -op_b : op_b;
    // Most negative value of the op width, as it appears after extension.
    min_val  = div_word_i ? {{(XLEN-31){1'b1}}, {31{1'b0}}}
                          : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (op_b == '0);
    sgn_ovf  = div_signed_i & (op_a == min_val) & (op_b == '1);
  end

  // Iteration datapath.
  logic [XLEN-1:0] step_rem, quo_shift;
  logic            step_q;

  div_step #(
    .XLEN (XLEN)
  ) u_step (
    .rem_i  (rem_q),
    .dvsr_i (dvsr_q),
    .bit_i  (quo_q[XLEN-1]),
    .rem_o  (step_rem),
    .q_o    (step_q)
  );

  assign quo_shift = {quo_q[XLEN-2:0], step_q};

  // Final sign fix-up, applied to the values produced by the last iteration.
  logic [XLEN-1:0] q_raw, q_neg, q_fix, r_neg, r_fix;

  always_comb begin
    q_raw = word_q ? {{(XLEN-32){1'b0}}, quo_shift[31:0]} : quo_shift;
    q_neg = neg_quo_q ? -q_raw : q_raw;
    r_neg = neg_rem_q ? -step_rem : step_rem;
    q_fix = word_q ? sext_w(q_neg[31:0]) : q_neg;
    r_fix = word_q ? sext_w(r_neg[31:0]) : r_neg;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    word_d      = word_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    if (flush_i) begin
      // Drops any work in flight and any request presented this cycle.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (div_valid_i) begin
            if (div_zero) begin
              quotient_d  = '1;
              remainder_d = div_word_i ? sext_w(dividend_i[31:0]) : dividend_i;
              state_d     = ST_DONE;
            end else if (sgn_ovf) begin
              quotient_d  = op_a;
              remainder_d = '0;
              state_d     = ST_DONE;
            end else begin
              rem_d     = '0;
              // Word ops are left-aligned so the MSB-first shift sees bit 31 first.
              quo_d     = div_word_i ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
              dvsr_d    = mag_b;
              neg_quo_d = sign_a ^ sign_b;
              neg_rem_d = sign_a;
              word_d    = div_word_i;
              cnt_d     = div_word_i ? DIV_CNT_W'(DIV_ITER_32) : DIV_CNT_W'(DIV_ITER_64);
              state_d   = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem_d = step_rem;
          quo_d = quo_shift;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == DIV_CNT_W'(1)) begin
            quotient_d  = q_fix;
            remainder_d = r_fix;
            state_d     = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      word_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      word_q      <= word_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign div_ready_o = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// tb_div_unit
//   Directed and randomized checks of div_unit against an arithmetic
//   reference model of the RV64M division rules.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_valid_i = 1'b0;
  logic        div_ready_o;
  logic        div_signed_i = 1'b0;
  logic        div_word_i = 1'b0;
  logic [63:0] dividend_i = '0;
  logic [63:0] divisor_i = '0;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [63:0] quotient_o;
  logic [63:0] remainder_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_unit #(
    .XLEN (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .div_valid_i  (div_valid_i),
    .div_ready_o  (div_ready_o),
    .div_signed_i (div_signed_i),
    .div_word_i   (div_word_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .flush_i      (flush_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics with plain integer arithmetic.
  function automatic void ref_div(input bit sgn, input bit wrd,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output int lat);
    logic [31:0] a32, b32, q32, r32;
    int          sa, sb;
    longint      la, lb;
    a32 = a[31:0];
    b32 = b[31:0];
    lat = wrd ? 33 : 65;
    if (wrd) begin
      if (b32 == '0) begin
        q32 = '1; r32 = a32; lat = 1;
      end else if (sgn) begin
        sa = a32; sb = b32;
        if (sa == 32'sh8000_0000 && sb == -1) begin
          q32 = a32; r32 = '0; lat = 1;
        end else begin
          q32 = sa / sb; r32 = sa % sb;
        end
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == '0) begin
        q = '1; r = a; lat = 1;
      end else if (sgn) begin
        la = a; lb = b;
        if (la == 64'sh8000_0000_0000_0000 && lb == -64'sd1) begin
          q = a; r = '0; lat = 1;
        end else begin
          q = la / lb; r = la % lb;
        end
      end else begin
        q = a / b; r = a % b;
      end
    end
  endfunction

  // Presents a request at a negedge; returns at the negedge after the accept edge.
  task automatic start_op(input bit sgn, input bit wrd, input logic [63:0] a, input logic [63:0] b);
    div_signed_i = sgn;
    div_word_i   = wrd;
    dividend_i   = a;
    divisor_i    = b;
    div_valid_i  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_valid_i  = 1'b0;
  endtask

  task automatic do_op(input string tag, input bit sgn, input bit wrd,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_q, input logic [63:0] exp_r,
                       input int exp_lat, input int hold);
    int c;
    @(negedge clk);
    out_ready_i = (hold == 0);
    chk({tag, "_ready_in"}, 64'(div_ready_o), 64'd1);
    start_op(sgn, wrd, a, b);
    c = 1;
    while (!out_valid_o && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_lat"}, 64'(c), 64'(exp_lat));
    chk({tag, "_q"}, quotient_o, exp_q);
    chk({tag, "_r"}, remainder_o, exp_r);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_bp_valid"}, 64'(out_valid_o), 64'd1);
      chk({tag, "_bp_ready"}, 64'(div_ready_o), 64'd0);
      chk({tag, "_bp_q"}, quotient_o, exp_q);
      chk({tag, "_bp_r"}, remainder_o, exp_r);
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    chk({tag, "_ready_out"}, 64'(div_ready_o), 64'd1);
    $display("op %s sgn=%0d w=%0d a=%h b=%h -> q=%h r=%h lat=%0d", tag, sgn, wrd, a, b,
             quotient_o, remainder_o, c);
  endtask

  initial begin
    logic [63:0] a, b, eq, er;
    int          lat;
    bit          sgn, wrd, seen;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(div_ready_o), 64'd1);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_q", quotient_o, 64'd0);
    chk("rst_r", remainder_o, 64'd0);
    rst_n = 1'b1;

    do_op("divu_100_7", 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65, 0);

    // Reset mid-CALC: everything back to reset values immediately.
    start_op(1'b0, 1'b0, 64'd100, 64'd7);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_ready", 64'(div_ready_o), 64'd1);
    chk("rstmid_valid", 64'(out_valid_o), 64'd0);
    chk("rstmid_q", quotient_o, 64'd0);
    chk("rstmid_r", remainder_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("op rst_mid_calc done");

    do_op("div_m7_2", 1'b1, 1'b0, -64'sd7, 64'd2, -64'sd3, -64'sd1, 65, 0);
    do_op("div_7_m2", 1'b1, 1'b0, 64'd7, -64'sd2, -64'sd3, 64'd1, 65, 0);
    do_op("divu_by0", 1'b0, 1'b0, 64'h1234, 64'd0, '1, 64'h1234, 1, 0);
    do_op("div_ovf", 1'b1, 1'b0, 64'h8000_0000_0000_0000, '1,
          64'h8000_0000_0000_0000, 64'd0, 1, 0);
    do_op("divw_ovf", 1'b1, 1'b1, 64'h0000_0000_8000_0000, '1,
          64'hFFFF_FFFF_8000_0000, 64'd0, 1, 0);
    do_op("divuw", 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2,
          64'h0000_0000_7FFF_FFFF, 64'h0000_0000_0000_0001, 33, 0);
    do_op("bp_hold5", 1'b0, 1'b0, 64'd1000, 64'd33, 64'd30, 64'd10, 65, 5);

    // Flush at CALC cycle 10, with a (dropped) request alongside it.
    start_op(1'b0, 1'b0, 64'd5000, 64'd3);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    div_valid_i = 1'b1;
    divisor_i = '0;
    @(negedge clk);
    flush_i = 1'b0;
    div_valid_i = 1'b0;
    chk("flush_valid", 64'(out_valid_o), 64'd0);
    chk("flush_ready", 64'(div_ready_o), 64'd1);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid_o) seen = 1'b1;
    end
    chk("flush_no_result", 64'(seen), 64'd0);
    // Flush together with a divide-by-zero request while idle.
    flush_i = 1'b1;
    div_valid_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    div_valid_i = 1'b0;
    chk("flush_idle_valid", 64'(out_valid_o), 64'd0);
    chk("flush_idle_ready", 64'(div_ready_o), 64'd1);
    $display("op flush checks done");

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      wrd = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(8, 60);
      case ($urandom_range(0, 4))
        0: b = {$urandom, $urandom};
        1: b = 64'($urandom_range(0, 15));
        2: b = {$urandom, $urandom} >> $urandom_range(1, 62);
        3: b = -64'($urandom_range(1, 9));
        default: b = {32'($urandom), 32'($urandom_range(1, 1000))};
      endcase
      ref_div(sgn, wrd, a, b, eq, er, lat);
      do_op("rand", sgn, wrd, a, b, eq, er, lat, int'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_div_unit
